// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states, iteration count.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MADD  = 3'd4,
    MD_MADDU = 3'd5,
    MD_MSUB  = 3'd6,
    MD_MSUBU = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_FIX
  } md_state_e;

  localparam int MD_ITERS = 32;

  function automatic logic [31:0] md_abs(input logic [31:0] v, input logic is_signed);
    md_abs = (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply step or restoring-divide step.
module muldiv_step #(
  parameter int W = 32
) (
  input  logic           i_div,
  input  logic [2*W-1:0] i_acc,
  input  logic [W-1:0]   i_opnd,
  output logic [2*W-1:0] o_acc
);

  logic [W:0] w_sum;
  logic [W:0] w_trial;
  logic       w_qbit;

  // Multiply: acc = {partial product hi, remaining multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    w_sum   = {1'b0, i_acc[2*W-1:W]} + (i_acc[0] ? {1'b0, i_opnd} : {(W+1){1'b0}});
    // 33-bit trial subtract; its MSB is set exactly when the subtract borrows.
    w_trial = {i_acc[2*W-1:W], i_acc[W-1]} - {1'b0, i_opnd};
    w_qbit  = ~w_trial[W];
    if (i_div)
      o_acc = {(w_qbit ? w_trial[W-1:0] : i_acc[2*W-2:W-1]), i_acc[W-2:0], w_qbit};
    else
      o_acc = {w_sum, i_acc[W-1:1]};
  end

endmodule

// File: rtl/muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; 33-cycle fixed latency.
// Define MULDIV_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e          r_state, w_state_nxt;
  logic [4:0]         r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd, r_a, r_hi, r_lo;
  logic               r_isdiv, r_divz, r_sa, r_neg, r_done;
`ifdef MULDIV_MADD_EN
  logic               r_macc, r_msub;
`endif

  logic               w_legal, w_accept, w_signed, w_isdiv;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_q, w_r;
  logic [2*WIDTH-1:0] w_step, w_prod, w_res;

`ifdef MULDIV_MADD_EN
  assign w_legal = 1'b1;
`else
  assign w_legal = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
`endif

  assign w_accept = (r_state == MD_IDLE) && start && w_legal;
  assign w_signed = (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
  assign w_isdiv  = (op == MD_DIV) || (op == MD_DIVU);
  assign w_abs_a  = md_abs(a, w_signed);
  assign w_abs_b  = md_abs(b, w_signed);

  muldiv_step #(.W(WIDTH)) u_step (
    .i_div  (r_isdiv),
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .o_acc  (w_step)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MD_IDLE: if (w_accept) w_state_nxt = MD_CALC;
      MD_CALC: if (r_cnt == 5'(MD_ITERS - 1)) w_state_nxt = MD_FIX;
      MD_FIX:  w_state_nxt = MD_IDLE;
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  // Sign fixup on magnitudes; divide-by-zero bypasses it entirely.
  always_comb begin
    w_prod = r_neg ? (~r_acc + 1'b1) : r_acc;
    w_q    = r_neg ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    w_r    = r_sa  ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
    w_res  = w_prod;
    if (r_isdiv)
      w_res = r_divz ? {r_a, {WIDTH{1'b1}}} : {w_r, w_q};
`ifdef MULDIV_MADD_EN
    else if (r_macc)
      w_res = r_msub ? ({r_hi, r_lo} - w_prod) : ({r_hi, r_lo} + w_prod);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      case (r_state)
        MD_IDLE: begin
          if (w_accept) begin
            r_cnt   <= '0;
            r_acc   <= {{WIDTH{1'b0}}, (w_isdiv ? w_abs_a : w_abs_b)};
            r_opnd  <= w_isdiv ? w_abs_b : w_abs_a;
            r_a     <= a;
            r_isdiv <= w_isdiv;
            r_divz  <= (b == '0);
            r_sa    <= w_signed & a[WIDTH-1];
            r_neg   <= w_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`ifdef MULDIV_MADD_EN
            r_macc  <= op[2];
            r_msub  <= op[2] & op[1];
`endif
          end else begin
            if (wr_hi) r_hi <= wdata;
            if (wr_lo) r_lo <= wdata;
          end
        end
        MD_CALC: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 5'd1;
        end
        MD_FIX: begin
          {r_hi, r_lo} <= w_res;
          r_done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != MD_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: directed test-plan vectors plus randomized traffic vs. an arithmetic model.
module tb_muldiv;

  logic        clk = 1'b0;
  logic        rst, start, wr_hi, wr_lo;
  logic [2:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  function automatic bit legal(input logic [2:0] o);
`ifdef MULDIV_MADD_EN
    legal = 1'b1;
`else
    legal = (o < 3'd4);
`endif
  endfunction

  // Architectural result of one op, from plain arithmetic.
  function automatic logic [63:0] ref_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                          input logic [63:0] hilo);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    p  = (o[0]) ? (64'(x) * 64'(y)) : 64'(sx * sy);
    case (o)
      3'd2: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        q = sx / sy; r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (y == 0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
      3'd4, 3'd5: return hilo + p;
      3'd6, 3'd7: return hilo - p;
      default: return p;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-level model: an accepted op lands its result 33 edges later.
  logic        m_valid = 1'b0;
  logic        m_busy, m_done;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  int          m_left;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1; m_busy = 1'b0; m_done = 1'b0; m_hi = '0; m_lo = '0; m_left = 0;
    end else if (m_valid) begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          {m_hi, m_lo} = m_res; m_done = 1'b1; m_busy = 1'b0;
        end
      end else if (start && legal(op)) begin
        m_res = ref_res(op, a, b, {m_hi, m_lo}); m_busy = 1'b1; m_left = 33;
      end else begin
        if (wr_hi) m_hi = wdata;
        if (wr_lo) m_lo = wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
      chk("cyc_done", {31'b0, done}, {31'b0, m_done});
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int k;
    k = 0;
    while (busy && k < 40) begin tick(); k++; end
    op = o; a = x; b = y; start = 1'b1; tick(); start = 1'b0;
    k = 0;
    while (!done && k < 40) begin tick(); k++; end
    n_chk++;
    if (!done) begin
      n_err++;
      $display("FAIL done_wait: op %0d got no done within 40 cycles", o);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return $urandom_range(7);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] mv;
    int ndone;
    rst = 1'b1; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; op = '0; a = '0; b = '0; wdata = '0;
    tick(); tick(); rst = 1'b0;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    // Pin the model to hand-computed values.
    mv = ref_res(3'd2, 32'h80000000, 32'hFFFFFFFF, 64'd0);
    chk("model_divovf_lo", mv[31:0], 32'h80000000);
    chk("model_divovf_hi", mv[63:32], 32'h0);
    mv = ref_res(3'd0, 32'hFFFFFFFE, 32'd3, 64'd0);
    chk("model_mult_hi", mv[63:32], 32'hFFFFFFFF);

    run_op(3'd0, 32'hFFFFFFFE, 32'd3);
    chk("mult_hi", hi, 32'hFFFFFFFF); chk("mult_lo", lo, 32'hFFFFFFFA);
    run_op(3'd1, 32'hFFFFFFFE, 32'd3);
    chk("multu_hi", hi, 32'h2); chk("multu_lo", lo, 32'hFFFFFFFA);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2);
    chk("div_lo", lo, 32'hFFFFFFFD); chk("div_hi", hi, 32'hFFFFFFFF);
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
    chk("divovf_lo", lo, 32'h80000000); chk("divovf_hi", hi, 32'h0);
    run_op(3'd3, 32'd5, 32'd0);
    chk("divz_hi", hi, 32'd5); chk("divz_lo", lo, 32'hFFFFFFFF);
    run_op(3'd2, 32'hFFFFFFF0, 32'd0);
    chk("sdivz_hi", hi, 32'hFFFFFFF0); chk("sdivz_lo", lo, 32'hFFFFFFFF);

    // MTLO then accumulate.
    do_reset();
    wdata = 32'd10; wr_lo = 1'b1; tick(); wr_lo = 1'b0;
    chk("mtlo", lo, 32'd10);
`ifdef MULDIV_MADD_EN
    run_op(3'd4, 32'd3, 32'd4);
    chk("madd_lo", lo, 32'd22); chk("madd_hi", hi, 32'd0);
`else
    op = 3'd4; a = 32'd3; b = 32'd4; start = 1'b1; tick(); start = 1'b0;
    chk("madd_off_busy", {31'b0, busy}, 32'd0);
    repeat (3) tick();
    chk("madd_off_lo", lo, 32'd10); chk("madd_off_hi", hi, 32'd0);
`endif

    // Mid-op start/MTHI are ignored, then reset discards the op.
    run_op(3'd0, 32'd7, 32'd9);
    op = 3'd2; a = 32'd100; b = 32'd7; start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    op = 3'd0; start = 1'b1; wr_hi = 1'b1; wdata = 32'hDEAD; tick(); start = 1'b0; wr_hi = 1'b0;
    chk("busy_mid", {31'b0, busy}, 32'd1);
    chk("mthi_ignored", hi, 32'd0);
    repeat (4) tick();
    do_reset();
    chk("rst2_busy", {31'b0, busy}, 32'd0);
    chk("rst2_hi", hi, 32'd0); chk("rst2_lo", lo, 32'd0);
    ndone = 0;
    repeat (40) begin tick(); if (done) ndone++; end
    chk("no_done_after_rst", ndone, 32'd0);

    // Random traffic; the compare process checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(3) == 0);
      op    = 3'($urandom_range(7));
      a     = pick();
      b     = pick();
      wr_hi = ($urandom_range(7) == 0);
      wr_lo = ($urandom_range(7) == 0);
      wdata = $urandom;
      rst   = ($urandom_range(599) == 0);
      tick();
    end
    rst = 1'b0; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
